// File: rtl/hr_dpwm_pkg.sv
// Shared types and width constants for the hybrid high-resolution DPWM sequencer.
package hr_dpwm_pkg;

   // Fine (delay-element) part of the duty word
   localparam int unsigned DE_bits      = 6;
   // Full duty word
   localparam int unsigned Dc_length    = 13;
   // Coarse part and period counter; one period is 2**Count_length cycles
   localparam int unsigned Count_length = Dc_length - DE_bits;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } dpwm_state_e;

   // Largest duty accepted: coarse = 2**Count_length - 2, fine = 0.
   // 2**C - 2 is all ones with the LSB cleared, so build it bitwise.
   function automatic logic [Dc_length-1:0] dc_max();
      logic [Dc_length-1:0] m;
      m                       = '0;
      m[Dc_length-1:DE_bits]  = '1;
      m[DE_bits]              = 1'b0;
      return m;
   endfunction

endpackage : hr_dpwm_pkg

// File: rtl/dpwm_dc_shadow.sv
// Duty command shadow: clamps incoming commands, holds one pending command
// behind a valid/ready handshake and moves it to the active duty at the
// period load point.
module dpwm_dc_shadow
   import hr_dpwm_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [Dc_length-1:0] dc_i,
   input  logic                 dc_valid_i,
   output logic                 dc_ready_o,
   input  logic                 load_i,
   output logic [Dc_length-1:0] dc_act_o,
   output logic                 dc_sat_o
);

   localparam logic [Dc_length-1:0] DC_MAX = dc_max();

   logic                 pend_q,   pend_d;
   logic [Dc_length-1:0] dc_buf_q, dc_buf_d;
   logic [Dc_length-1:0] dc_act_q, dc_act_d;
   logic                 dc_sat_q, dc_sat_d;
   logic                 over;
   logic                 accept;
   logic [Dc_length-1:0] dc_clamped;

   // Clamp, accept into the buffer, or promote the buffer to the active duty
   always_comb begin
      over       = (dc_i > DC_MAX);
      dc_clamped = over ? DC_MAX : dc_i;
      accept     = dc_valid_i && !pend_q;

      pend_d     = pend_q;
      dc_buf_d   = dc_buf_q;
      dc_act_d   = dc_act_q;
      dc_sat_d   = 1'b0;

      // Accept needs pend=0 and load needs pend=1, so they never coincide
      if (accept) begin
         dc_buf_d = dc_clamped;
         pend_d   = 1'b1;
         dc_sat_d = over;
      end else if (load_i && pend_q) begin
         dc_act_d = dc_buf_q;
         pend_d   = 1'b0;
      end
   end

   // Command buffer, pending flag, active duty and saturation pulse registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_q   <= 1'b0;
         dc_buf_q <= '0;
         dc_act_q <= '0;
         dc_sat_q <= 1'b0;
      end else begin
         pend_q   <= pend_d;
         dc_buf_q <= dc_buf_d;
         dc_act_q <= dc_act_d;
         dc_sat_q <= dc_sat_d;
      end
   end

   assign dc_ready_o = !pend_q;
   assign dc_act_o   = dc_act_q;
   assign dc_sat_o   = dc_sat_q;

   // The active duty can only ever hold a clamped value
   a_act_clamped: assert property (@(posedge clk_i) disable iff (rst_i)
      dc_act_q <= DC_MAX);

endmodule : dpwm_dc_shadow

// File: rtl/hr_dpwm_ctrl.sv
// Period and duty-cycle sequencer for the hybrid high-resolution DPWM.
// Generates the coarse L_DPWM pulse and the per-period fine delay select.
module hr_dpwm_ctrl
   import hr_dpwm_pkg::*;
(
   input  logic                    clk_base,
   input  logic                    rst,
   input  logic                    en,
   input  logic [Dc_length-1:0]    dc_in,
   input  logic                    dc_valid,
   output logic                    dc_ready,
   output logic                    L_DPWM,
   output logic [DE_bits-1:0]      de_sel,
   output logic [Count_length-1:0] period_cnt,
   output logic                    period_start,
   output logic                    dc_sat,
   output logic                    busy
);

   localparam logic [Count_length-1:0] CNT_LAST = '1;

   dpwm_state_e               state_q, state_d;
   logic [Count_length-1:0]   cnt_q,   cnt_d;
   logic                      load;
   logic [Dc_length-1:0]      dc_act;
   logic [Count_length-1:0]   coarse;
   logic                      running;

   dpwm_dc_shadow u_shadow (
      .clk_i      (clk_base),
      .rst_i      (rst),
      .dc_i       (dc_in),
      .dc_valid_i (dc_valid),
      .dc_ready_o (dc_ready),
      .load_i     (load),
      .dc_act_o   (dc_act),
      .dc_sat_o   (dc_sat)
   );

   // Next state, next counter value and the period load point
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (en) begin
               state_d = ST_RUN;
               load    = 1'b1;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q + 1'b1;
            load  = (cnt_q == CNT_LAST);
            if (!en) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            cnt_d = cnt_q + 1'b1;
            load  = (cnt_q == CNT_LAST);
            if (en) begin
               state_d = ST_RUN;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and period counter registers
   always_ff @(posedge clk_base or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decoded purely from registered state, counter and active duty
   always_comb begin
      running      = (state_q != ST_IDLE);
      coarse       = dc_act[Dc_length-1:DE_bits];
      L_DPWM       = running && (cnt_q < coarse);
      de_sel       = dc_act[DE_bits-1:0];
      period_cnt   = cnt_q;
      period_start = running && (cnt_q == '0);
      busy         = running;
   end

   // Clamping keeps coarse <= N-2, so the pulse is always low at the wrap
   a_low_at_wrap: assert property (@(posedge clk_base) disable iff (rst)
      (cnt_q == CNT_LAST) |-> !L_DPWM);

   // The counter is held at zero while idle
   a_idle_zero: assert property (@(posedge clk_base) disable iff (rst)
      (state_q == ST_IDLE) |-> (cnt_q == '0));

endmodule : hr_dpwm_ctrl

// File: tb/tb_hr_dpwm_ctrl.sv
// Self-checking bench for hr_dpwm_ctrl: expected per-period results are
// queued when stimulus is applied and checked as each period completes.
module tb_hr_dpwm_ctrl;

   logic        clk_base;
   logic        rst;
   logic        en;
   logic [12:0] dc_in;
   logic        dc_valid;
   logic        dc_ready;
   logic        L_DPWM;
   logic [5:0]  de_sel;
   logic [6:0]  period_cnt;
   logic        period_start;
   logic        dc_sat;
   logic        busy;

   hr_dpwm_ctrl dut (
      .clk_base     (clk_base),
      .rst          (rst),
      .en           (en),
      .dc_in        (dc_in),
      .dc_valid     (dc_valid),
      .dc_ready     (dc_ready),
      .L_DPWM       (L_DPWM),
      .de_sel       (de_sel),
      .period_cnt   (period_cnt),
      .period_start (period_start),
      .dc_sat       (dc_sat),
      .busy         (busy)
   );

   initial clk_base = 1'b0;
   always #5 clk_base = ~clk_base;

   typedef struct {
      int coarse;
      int de;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic push_exp(input int coarse, input int de, input int n);
      exp_t e;
      e.coarse = coarse;
      e.de     = de;
      for (int i = 0; i < n; i++) exp_q.push_back(e);
   endtask

   task automatic wait_cnt(input int v, input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_base);
         if (period_cnt == 7'(v)) begin
            found = 1'b1;
            break;
         end
      end
      chk(tag, found, 1);
   endtask

   task automatic wait_q_empty(input string tag);
      bit done = 1'b0;
      for (int i = 0; i < 700; i++) begin
         @(negedge clk_base);
         #1;
         if (exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      chk(tag, done, 1);
   endtask

   task automatic wait_idle(input string tag);
      bit done = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_base);
         if (!busy) begin
            done = 1'b1;
            break;
         end
      end
      chk(tag, done, 1);
   endtask

   // Leaves the caller at the falling edge after the transfer edge
   task automatic send_cmd(input logic [12:0] v);
      chk("ready_before_send", dc_ready, 1);
      dc_in    = v;
      dc_valid = 1'b1;
      @(posedge clk_base);
      #1;
      dc_valid = 1'b0;
      @(negedge clk_base);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cnt"},   period_cnt,   0);
      chk({tag, "_pwm"},   L_DPWM,       0);
      chk({tag, "_de"},    de_sel,       0);
      chk({tag, "_ps"},    period_start, 0);
      chk({tag, "_sat"},   dc_sat,       0);
      chk({tag, "_busy"},  busy,         0);
      chk({tag, "_ready"}, dc_ready,     1);
   endtask

   // Period monitor: measures each complete period and pops its expectation
   int   cyc     = 0;
   int   last_ps = 0;
   bit   ps_valid = 1'b0;
   bit   open    = 1'b0;
   int   hi, fall, de_first;
   bit   de_ok;
   always @(negedge clk_base) begin
      if (rst) begin
         open     = 1'b0;
         ps_valid = 1'b0;
      end else begin
         cyc++;
         if (period_start) begin
            if (ps_valid) chk("ps_gap", cyc - last_ps, 128);
            last_ps  = cyc;
            ps_valid = 1'b1;
            open     = 1'b1;
            hi       = 0;
            fall     = 128;
            de_first = int'(de_sel);
            de_ok    = 1'b1;
         end
         if (!busy) ps_valid = 1'b0;
         if (open) begin
            if (L_DPWM) hi++;
            else if (fall == 128) fall = int'(period_cnt);
            if (int'(de_sel) != de_first) de_ok = 1'b0;
            if (period_cnt == 7'd127) begin
               open = 1'b0;
               if (exp_q.size() > 0) begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("pwm_high_cycles", hi,       e.coarse);
                  chk("pwm_fall_index",  fall,     e.coarse);
                  chk("de_sel_period",   de_first, e.de);
                  chk("de_sel_stable",   de_ok,    1);
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      dc_in    = '0;
      dc_valid = 1'b0;
      repeat (3) @(negedge clk_base);
      check_reset_outputs("in_reset");
      rst = 1'b0;
      @(negedge clk_base);
      check_reset_outputs("after_reset");

      // No command: pulse stays low, de_sel zero, period_start every 128
      push_exp(0, 0, 2);
      en = 1'b1;
      @(negedge clk_base);
      chk("first_run_cnt", period_cnt, 0);
      chk("first_run_ps", period_start, 1);
      chk("first_run_busy", busy, 1);
      wait_q_empty("q_no_cmd");
      en = 1'b0;
      wait_idle("idle_after_no_cmd");

      // Command while idle applies from the first run period
      send_cmd(13'h0A15);
      chk("ready_pending_idle", dc_ready, 0);
      push_exp(40, 8'h15, 2);
      en = 1'b1;
      @(negedge clk_base);
      chk("ready_after_load", dc_ready, 1);
      chk("de_sel_first", de_sel, 8'h15);
      chk("pwm_first", L_DPWM, 1);
      wait_q_empty("q_idle_cmd");

      // Mid-period update lands on the next period boundary
      wait_cnt(60, "wait_cnt60_a");
      push_exp(40, 8'h15, 1);
      push_exp(16, 5, 2);
      send_cmd(13'h0405);
      chk("ready_pending_run", dc_ready, 0);
      chk("sat_not_clamped", dc_sat, 0);
      chk("de_sel_old_kept", de_sel, 8'h15);
      wait_cnt(0, "wait_cnt0_a");
      chk("ready_at_boundary", dc_ready, 1);
      chk("de_sel_new", de_sel, 5);
      wait_q_empty("q_mid_cmd");

      // Oversized command is clamped to 0x1F80 with a one-cycle dc_sat
      wait_cnt(60, "wait_cnt60_b");
      push_exp(16, 5, 1);
      push_exp(126, 0, 2);
      send_cmd(13'h1FFF);
      chk("sat_pulse", dc_sat, 1);
      @(negedge clk_base);
      chk("sat_one_cycle", dc_sat, 0);
      wait_q_empty("q_clamp");

      // Drop en mid-period: the period completes, then idle at count 0
      push_exp(126, 0, 1);
      wait_cnt(50, "wait_cnt50");
      en = 1'b0;
      wait_cnt(127, "wait_cnt127");
      chk("busy_last_drain", busy, 1);
      @(negedge clk_base);
      chk("busy_fell", busy, 0);
      chk("idle_cnt", period_cnt, 0);
      chk("idle_pwm", L_DPWM, 0);
      chk("idle_ps", period_start, 0);
      repeat (3) @(negedge clk_base);
      chk("idle_cnt_held", period_cnt, 0);
      chk("q_drain_empty", exp_q.size(), 0);

      // Re-raising en during drain keeps the waveform continuous
      push_exp(126, 0, 1);
      en = 1'b1;
      wait_cnt(30, "wait_cnt30");
      en = 1'b0;
      wait_cnt(100, "wait_cnt100");
      chk("busy_in_drain", busy, 1);
      en = 1'b1;
      push_exp(126, 0, 1);
      wait_q_empty("q_redrain");

      // Reset mid-period with a command pending: discarded, next run uses 0
      wait_cnt(10, "wait_cnt10");
      send_cmd(13'h0A15);
      chk("ready_pending_pre_rst", dc_ready, 0);
      wait_cnt(20, "wait_cnt20");
      rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      @(negedge clk_base);
      en = 1'b0;
      @(negedge clk_base);
      rst = 1'b0;
      @(negedge clk_base);
      check_reset_outputs("post_rst");
      push_exp(0, 0, 1);
      en = 1'b1;
      @(negedge clk_base);
      chk("post_rst_de", de_sel, 0);
      chk("post_rst_pwm", L_DPWM, 0);
      wait_q_empty("q_post_rst");
      en = 1'b0;
      wait_idle("final_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_hr_dpwm_ctrl

// File: doc/hr_dpwm_ctrl.md
# hr_dpwm_ctrl

Period and duty-cycle sequencer for the hybrid high-resolution DPWM. It accepts duty commands over a valid/ready handshake and splits each command into a coarse count (MSBs) and a delay-element select (LSBs). It generates the low-resolution `L_DPWM` pulse and holds the fine select that the edge-counting flag counter and delay line use to place the falling edge. Duty changes take effect only at period boundaries, so no period ever mixes old and new settings.

## Interface
- `DE_bits`, 6: width of the fine (delay-element) part of the duty word.
- `Dc_length`, 13: width of the full duty word.
- `Count_length`, `Dc_length-DE_bits`: width of the coarse part and of the period counter. Period N = 2^Count_length cycles.
- `DC_MAX`, `((2**Count_length)-2) << DE_bits`: largest duty accepted; larger commands are clamped.
- `clk_base`  in  1  base clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `en`  in  1  run request (level).
- `dc_in`  in  Dc_length  duty command.
- `dc_valid`  in  1  command valid.
- `dc_ready`  out  1  command buffer free.
- `L_DPWM`  out  1  coarse PWM output.
- `de_sel`  out  DE_bits  fine delay select for the current period.
- `period_cnt`  out  Count_length  period counter.
- `period_start`  out  1  high in the cycle where `period_cnt`==0 while running.
- `dc_sat`  out  1  one-cycle pulse: last accepted command was clamped.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states:
  - IDLE: counter held at 0; `L_DPWM`=0; `period_start`=0.
  - RUN: counter increments mod N.
  - DRAIN: counter increments; finishes the current period.
- FSM transitions:
  - IDLE→RUN when `en`=1. The first RUN cycle has `period_cnt`=0.
  - RUN→DRAIN when `en`=0.
  - DRAIN→RUN when `en`=1, with no gap or counter reset.
  - DRAIN→IDLE at the edge where `period_cnt` wraps from N-1. The current period always completes.
- Command buffer: register `dc_buf` plus flag `pend`.
  - `dc_ready` = !`pend`.
  - A transfer occurs when `dc_valid`&&`dc_ready`. It stores min(`dc_in`, `DC_MAX`) and sets `pend`.
  - `dc_sat` pulses in the cycle after a transfer whose input exceeded `DC_MAX`.
- Load point: the edge into `period_cnt`==0, i.e. the wrap from N-1, or IDLE→RUN.
  - At the load point, if `pend`=1: `dc_act`←`dc_buf` and `pend`←0.
  - Otherwise `dc_act` is unchanged.
  - Accept and load never coincide, because accept requires `pend`=0 and load requires `pend`=1.
- `coarse` = `dc_act[Dc_length-1:DE_bits]`. `de_sel` = `dc_act[DE_bits-1:0]`, stable for the whole period.
- `L_DPWM`=1 exactly in running cycles with `period_cnt` < `coarse`.
  - `coarse`=0: `L_DPWM` stays 0. The fine part still drives `de_sel`.
  - `L_DPWM` never stays high across a wrap, because clamping guarantees `coarse` ≤ N-2.
- Arithmetic: the counter is unsigned, wraps N-1→0, and has no carry out. Comparisons are unsigned at Count_length bits.

## Timing
- Reset values:
  - State IDLE.
  - `period_cnt`, `dc_act`, `dc_buf`, `pend` all 0.
  - `L_DPWM`, `de_sel`, `period_start`, `dc_sat`, `busy` all 0.
  - `dc_ready`=1.
- All outputs come directly from flops or are decoded only from registered state. There are no input-to-output combinational paths, except that `dc_ready` depends only on `pend`.
- Command latency: a transfer in period k affects period k+1. If the transfer happens while IDLE, it takes effect at the first RUN period.
- `en` deassert: `L_DPWM` continues until the natural end of the current period.
- `rst` mid-period: all outputs return to their reset values immediately (asynchronously). A pending command is discarded.

## Structure
- Shared package `hr_dpwm_pkg` holds:
  - the state enum (IDLE/RUN/DRAIN);
  - the width constants `DE_bits`, `Dc_length`, `Count_length`;
  - the `DC_MAX` function.
- One sub-module, `dpwm_dc_shadow`: clamp, `dc_buf`/`pend` handshake and `dc_act` load. The top contains the FSM, counter and output decode.

## Test plan
All values below use the defaults (N=128).
- Reset then `en`=1 with no command → `L_DPWM` stays 0, `period_start` pulses every 128 cycles, `de_sel`=0.
- Send `dc_in`=0x0A15 in IDLE, then `en`=1 → in every period `L_DPWM` is high for `period_cnt` 0..39 (coarse 40) and `de_sel`=0x15.
- Send 0x0A15, then 0x0405 mid-period → `dc_ready` goes low, the new values apply from the next `period_cnt`=0, and `dc_ready` rises in that cycle.
- Send `dc_in`=0x1FFF → `dc_sat` pulses once, the applied duty is 0x1F80 (coarse 126), and `L_DPWM` falls at `period_cnt`=126.
- Drop `en` at `period_cnt`=50 → the period completes, `busy` falls after the `period_cnt`=127 cycle, and `period_cnt`=0 remains in IDLE. Re-raising `en` during DRAIN keeps the waveform uninterrupted.
- Assert `rst` at `period_cnt`=20 with a command pending → all outputs return to reset values at once, `dc_ready`=1, and the next run uses duty 0.
